trojan_lockstep_monitor: RTL and testbench

Synthesizable on-chip successor to the bench-level Trojan check: drives one pseudo-random state/key stream into a suspect AES core and a golden AES core in lockstep, compares their outputs after a fixed pipeline latency, and reports whether, how often, and first where they diverge. It sits beside the two `aes_128`-style cores in the security test harness and replaces `$random` stimulus with on-chip LFSRs, so detection runs in silicon or FPGA.

---
 rtl/trojan_lockstep_monitor.sv | 189 ++++++++++++++++++
 tb/tb_trojan_lockstep_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_lockstep_monitor.sv
// Lockstep Trojan monitor: LFSR stimulus to suspect/golden AES cores, latency-aligned compare, first-mismatch capture.
// Optional macro TROJAN_MON_CAPTURE_EN adds the stimulus delay line so cap_state/cap_key hold the first failing vector.
module trojan_lockstep_monitor #(
  parameter int unsigned  DATA_W     = 128,
  parameter int unsigned  LATENCY    = 21,
  parameter int unsigned  NUM_TESTS  = 100,
  parameter logic [127:0] SEED_STATE = 128'h1,
  parameter logic [127:0] SEED_KEY   = 128'h2,
  parameter int unsigned  CNT_W      = $clog2(NUM_TESTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] state,
  output logic [DATA_W-1:0] key,
  output logic              stim_valid,
  input  logic [DATA_W-1:0] dut_out,
  input  logic [DATA_W-1:0] golden_out,
  output logic              busy,
  output logic              done,
  output logic              detected,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_idx,
  output logic [DATA_W-1:0] cap_state,
  output logic [DATA_W-1:0] cap_key,
  output logic [DATA_W-1:0] cap_golden,
  output logic [DATA_W-1:0] cap_dut
);

  localparam int unsigned  DRN_W = $clog2(LATENCY + 1);
  localparam int unsigned  TAIL  = LATENCY - 1;
  // Low-order terms of x^128+x^126+x^101+x^99+1, folded back in when bit 127 shifts out.
  localparam logic [127:0] POLY_LOW = 128'h40000028_00000000_00000000_00000001;
  localparam logic [127:0] SEED_S   = (SEED_STATE == '0) ? 128'h1 : SEED_STATE;
  localparam logic [127:0] SEED_K   = (SEED_KEY == '0) ? 128'h1 : SEED_KEY;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_TESTS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fsm_t;

  fsm_t             fsm;
  logic [127:0]     lfsr_s;
  logic [127:0]     lfsr_k;
  logic [CNT_W-1:0] iss_idx;
  logic [DRN_W-1:0] drain_cnt;
  logic             start_ok;
  logic             hit;

  logic [LATENCY-1:0]            dl_valid;
  logic [LATENCY-1:0][CNT_W-1:0] dl_idx;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? POLY_LOW : '0);
  endfunction

  assign start_ok = start && ((fsm == S_IDLE) || (fsm == S_DONE));
  assign hit      = dl_valid[TAIL] && (dut_out != golden_out);

  // Sequencer: the LFSRs always hold the vector after the one on state/key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= S_IDLE;
      lfsr_s     <= SEED_S;
      lfsr_k     <= SEED_K;
      state      <= '0;
      key        <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iss_idx    <= '0;
      drain_cnt  <= '0;
    end else begin
      case (fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            fsm        <= S_RUN;
            state      <= SEED_S[DATA_W-1:0];
            key        <= SEED_K[DATA_W-1:0];
            lfsr_s     <= lfsr_step(SEED_S);
            lfsr_k     <= lfsr_step(SEED_K);
            stim_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            iss_idx    <= '0;
          end
        end
        S_RUN: begin
          if (iss_idx == LAST_IDX) begin
            fsm        <= S_DRAIN;
            stim_valid <= 1'b0;
            drain_cnt  <= '0;
          end else begin
            iss_idx <= iss_idx + CNT_W'(1);
            state   <= lfsr_s[DATA_W-1:0];
            key     <= lfsr_k[DATA_W-1:0];
            lfsr_s  <= lfsr_step(lfsr_s);
            lfsr_k  <= lfsr_step(lfsr_k);
          end
        end
        S_DRAIN: begin
          // One cycle beyond LATENCY so the last compare has landed in the result registers.
          if (drain_cnt == DRAIN_LAST) begin
            fsm  <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_valid <= '0;
      dl_idx   <= '0;
    end else begin
      dl_valid[0] <= stim_valid;
      dl_idx[0]   <= iss_idx;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        dl_valid[k] <= dl_valid[k-1];
        dl_idx[k]   <= dl_idx[k-1];
      end
    end
  end

`ifdef TROJAN_MON_CAPTURE_EN
  logic [LATENCY-1:0][DATA_W-1:0] dl_state;
  logic [LATENCY-1:0][DATA_W-1:0] dl_key;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_state <= '0;
      dl_key   <= '0;
    end else begin
      dl_state[0] <= state;
      dl_key[0]   <= key;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        dl_state[k] <= dl_state[k-1];
        dl_key[k]   <= dl_key[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_state <= '0;
      cap_key   <= '0;
    end else if (start_ok) begin
      cap_state <= '0;
      cap_key   <= '0;
    end else if (hit && !detected) begin
      cap_state <= dl_state[TAIL];
      cap_key   <= dl_key[TAIL];
    end
  end
`else
  assign cap_state = '0;
  assign cap_key   = '0;
`endif

  // A start is only accepted in IDLE/DONE, where the delay line is already empty, so it never races a hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      detected       <= 1'b0;
      mismatch_count <= '0;
      first_idx      <= '0;
      cap_golden     <= '0;
      cap_dut        <= '0;
    end else if (start_ok) begin
      detected       <= 1'b0;
      mismatch_count <= '0;
      first_idx      <= '0;
      cap_golden     <= '0;
      cap_dut        <= '0;
    end else if (hit) begin
      mismatch_count <= mismatch_count + CNT_W'(1);
      if (!detected) begin
        detected   <= 1'b1;
        first_idx  <= dl_idx[TAIL];
        cap_golden <= golden_out;
        cap_dut    <= dut_out;
      end
    end
  end

endmodule

// File: tb/tb_trojan_lockstep_monitor.sv
// Bench for trojan_lockstep_monitor: behavioural reference (vector arithmetic over GF(2)[x]) checked every cycle,
// plus directed literal checks; honours TROJAN_MON_CAPTURE_EN for the cap_state/cap_key expectations.
module tb_trojan_lockstep_monitor;

  localparam int DW   = 128;
  localparam int L    = 2;
  localparam int N    = 8;
  localparam int CW   = $clog2(N + 1);
  localparam int DONE_REL = N + L + 2;
  localparam logic [127:0] SEED_S = 128'h1;
  localparam logic [127:0] SEED_K = 128'h2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] state, key, dut_out, golden_out;
  logic          stim_valid, busy, done, detected;
  logic [CW-1:0] mismatch_count, first_idx;
  logic [DW-1:0] cap_state, cap_key, cap_golden, cap_dut;

  int n_checks = 0;
  int n_fail   = 0;

  trojan_lockstep_monitor #(
    .DATA_W(DW), .LATENCY(L), .NUM_TESTS(N), .SEED_STATE(SEED_S), .SEED_KEY(SEED_K)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .key(key), .stim_valid(stim_valid),
    .dut_out(dut_out), .golden_out(golden_out), .busy(busy), .done(done), .detected(detected),
    .mismatch_count(mismatch_count), .first_idx(first_idx), .cap_state(cap_state),
    .cap_key(cap_key), .cap_golden(cap_golden), .cap_dut(cap_dut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Multiply by x modulo x^128+x^126+x^101+x^99+1.
  function automatic logic [127:0] mulx(input logic [127:0] v);
    logic carry;
    logic [127:0] r;
    carry = v[127];
    r = v << 1;
    if (carry) begin
      r[126] = ~r[126];
      r[101] = ~r[101];
      r[99]  = ~r[99];
      r[0]   = ~r[0];
    end
    return r;
  endfunction

  function automatic logic [127:0] vec(input logic [127:0] seed, input int i);
    logic [127:0] v;
    v = (seed == '0) ? 128'h1 : seed;
    for (int j = 0; j < i; j++) v = mulx(v);
    return v;
  endfunction

  function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
    return (s ^ {k[63:0], k[127:64]}) + 128'h9E3779B9;
  endfunction

  // Two cores: same L-stage pipeline, suspect output corrupted by a per-vector fault mask.
  logic [127:0] fault_mask [N];
  logic [127:0] pipe_g [L];
  logic         pipe_v [L];
  int           pipe_id [L];
  logic         prev_sv = 1'b0;
  int           last_id = 0;

  always @(posedge clk) begin : cores
    int cid;
    cid = prev_sv ? last_id + 1 : 0;
    prev_sv <= stim_valid;
    if (stim_valid) last_id <= cid;
    pipe_g[0]  <= core_f(state, key);
    pipe_v[0]  <= stim_valid;
    pipe_id[0] <= stim_valid ? cid : 0;
    for (int k = 1; k < L; k++) begin
      pipe_g[k]  <= pipe_g[k-1];
      pipe_v[k]  <= pipe_v[k-1];
      pipe_id[k] <= pipe_id[k-1];
    end
  end

  assign golden_out = pipe_g[L-1];
  assign dut_out    = pipe_g[L-1] ^ ((pipe_v[L-1] && pipe_id[L-1] < N) ? fault_mask[pipe_id[L-1]] : '0);

  // Reference: rel = cycles since the accepted start (start cycle is rel 0).
  bit           have_run = 0;
  int           rel = 0;
  logic [127:0] run_mask [N];

  always @(posedge clk) begin : model
    if (!rst) begin
      have_run = 0;
    end else if (start && (!have_run || rel >= DONE_REL)) begin
      have_run = 1;
      rel = 1;
      for (int i = 0; i < N; i++) run_mask[i] = fault_mask[i];
    end else if (have_run && rel < 100000) begin
      rel++;
    end
  end

  always @(negedge clk) begin : compare
    logic [127:0] es, ek, eg, ed, ecs, eck;
    bit eb, esv, edn;
    int cnt, first, vi;
    es = '0; ek = '0; eg = '0; ed = '0; ecs = '0; eck = '0;
    eb = 0; esv = 0; edn = 0; cnt = 0; first = -1;
    if (rst && have_run) begin
      eb  = (rel >= 1) && (rel <= N + L + 1);
      esv = (rel >= 1) && (rel <= N);
      edn = rel >= DONE_REL;
      vi  = ((rel <= N) ? rel : N) - 1;
      es  = vec(SEED_S, vi);
      ek  = vec(SEED_K, vi);
      for (int i = 0; i < N; i++) begin
        if (run_mask[i] != '0 && i + L + 2 <= rel) begin
          cnt++;
          if (first < 0) first = i;
        end
      end
      if (first >= 0) begin
        eg = core_f(vec(SEED_S, first), vec(SEED_K, first));
        ed = eg ^ run_mask[first];
`ifdef TROJAN_MON_CAPTURE_EN
        ecs = vec(SEED_S, first);
        eck = vec(SEED_K, first);
`endif
      end
    end
    chk("busy", busy, eb);
    chk("stim_valid", stim_valid, esv);
    chk("done", done, edn);
    chk("state", state, es);
    chk("key", key, ek);
    chk("detected", detected, cnt > 0);
    chk("mismatch_count", mismatch_count, cnt);
    chk("first_idx", first_idx, (first < 0) ? 0 : first);
    chk("cap_golden", cap_golden, eg);
    chk("cap_dut", cap_dut, ed);
    chk("cap_state", cap_state, ecs);
    chk("cap_key", cap_key, eck);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_masks(input int mode, input int only);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: fault_mask[i] = '0;
        1: fault_mask[i] = (i == only) ? 128'h1 : '0;
        2: fault_mask[i] = '1;
        default: begin
          fault_mask[i] = ($urandom_range(0, 2) == 0) ?
                          {$urandom, $urandom, $urandom, $urandom} | 128'h1 : '0;
        end
      endcase
    end
  endtask

  // Pulses start (cycle 0) and follows the run to done; optional spurious start and mid-run reset.
  task automatic do_run(input int extra_start_at, input int reset_at,
                        output int done_cyc, output int sv_cnt,
                        output logic [127:0] s1, output logic [127:0] k1, output logic [127:0] s2,
                        output int cnt_c1);
    done_cyc = -1; sv_cnt = 0; s1 = 'x; k1 = 'x; s2 = 'x; cnt_c1 = -1;
    start = 1'b1;
    tick;
    for (int c = 1; c <= 60; c++) begin
      if (stim_valid) sv_cnt++;
      if (c == 1) begin s1 = state; k1 = key; cnt_c1 = int'(mismatch_count) + int'(detected); end
      if (c == 2) s2 = state;
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        break;
      end
      if (c == reset_at) begin
        start = 1'b0;
        rst = 1'b0;
        tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state, '0);
        chk("rst_count", mismatch_count, '0);
        tick;
        rst = 1'b1;
        tick;
        break;
      end
      start = (c == extra_start_at);
      tick;
    end
    start = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : main
    int dc, sv, c1, cnt_a, first_a;
    logic [127:0] s1, k1, s2;
    logic [127:0] ones;
    ones = '1;
    set_masks(0, 0);
    repeat (3) tick;
    rst = 1'b1;
    tick;

    chk("mulx_taps", mulx(128'h80000000_00000000_00000000_00000000),
        128'h40000028_00000000_00000000_00000001);

    // Clean run: done at cycle 12, vectors 0/1 are seed and seed*x.
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    chk("clean_done_cycle", dc, 12);
    chk("clean_sv_cycles", sv, 8);
    chk("clean_vec0_state", s1, 128'h1);
    chk("clean_vec0_key", k1, 128'h2);
    chk("clean_vec1_state", s2, 128'h2);
    chk("clean_count", mismatch_count, 0);
    chk("clean_detected", detected, 0);

    // Single bit-0 flip on vector 5.
    set_masks(1, 5);
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    chk("v5_count", mismatch_count, 1);
    chk("v5_first_idx", first_idx, 5);
    chk("v5_cap_xor", cap_dut ^ cap_golden, 128'h1);
`ifdef TROJAN_MON_CAPTURE_EN
    chk("v5_cap_state", cap_state, 128'h20);
    chk("v5_cap_key", cap_key, 128'h40);
`endif

    // Suspect core fully inverted.
    set_masks(2, 0);
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    chk("inv_count", mismatch_count, 8);
    chk("inv_first_idx", first_idx, 0);
    chk("inv_cap_xor", cap_dut ^ cap_golden, ones);

    // Spurious start inside RUN.
    set_masks(0, 0);
    do_run(4, -1, dc, sv, s1, k1, s2, c1);
    chk("restart_ignored_done_cycle", dc, 12);
    chk("restart_ignored_sv_cycles", sv, 8);

    // Reset at cycle 6, then a fresh run restarts from the seeds.
    set_masks(1, 2);
    do_run(-1, 6, dc, sv, s1, k1, s2, c1);
    chk("reset_no_done", dc, -1);
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    chk("post_reset_vec0_state", s1, 128'h1);
    chk("post_reset_vec0_key", k1, 128'h2);
    chk("post_reset_count", mismatch_count, 1);
    chk("post_reset_first", first_idx, 2);

    // Restart from DONE with a random fault pattern: identical results, cleared at cycle 1.
    set_masks(3, 0);
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    cnt_a = int'(mismatch_count);
    first_a = int'(first_idx);
    do_run(-1, -1, dc, sv, s1, k1, s2, c1);
    chk("rerun_cleared_c1", c1, 0);
    chk("rerun_vec0_state", s1, 128'h1);
    chk("rerun_count", mismatch_count, cnt_a);
    chk("rerun_first", first_idx, first_a);
    chk("rerun_done_cycle", dc, 12);

    // Randomized runs: fault patterns, idle gaps, spurious starts (incl. last DRAIN cycle), resets.
    for (int r = 0; r < 16; r++) begin
      int xs, ra;
      set_masks(3, 0);
      repeat ($urandom_range(0, 3)) tick;
      xs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + L + 1)) : -1;
      ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N + L)) : -1;
      do_run(xs, ra, dc, sv, s1, k1, s2, c1);
      if (ra < 0) chk("rand_done_cycle", dc, 12);
    end

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
